// File: rtl/reg_bus_arbiter.sv
// Round-robin sequencer for the shared management register bus (port A host bridge, port B engine).
// Optional access timeout with error response is compiled in with `define CORETSE_REG_TIMEOUT_EN.
module reg_bus_arbiter #(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int TO_W           = 8
) (
   input  logic            HCLK,
   input  logic            HRESETn,
   input  logic            a_req,
   input  logic            a_wr,
   input  logic [4:0]      a_addr,
   input  logic [31:0]     a_wdata,
   output logic            a_done,
   input  logic            b_req,
   input  logic            b_wr,
   input  logic [4:0]      b_addr,
   input  logic [31:0]     b_wdata,
   output logic            b_done,
   output logic [31:0]     rsp_rdata,
   output logic            rsp_err,
   output logic            reg_inh,
   output logic [4:0]      reg_addr,
   output logic            reg_wr,
   output logic [31:0]     reg_wdata,
   input  logic [31:0]     reg_rdata,
   input  logic            reg_ack,
   output logic            busy,
   output logic [TO_W-1:0] timeout_cnt
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
   typedef enum logic {GRANT_A, GRANT_B} grant_e;

   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 256) begin : g_bad_timeout
      $error("reg_bus_arbiter: TIMEOUT_CYCLES must be in 2..256");
   end

   state_e      state_q, state_d;
   grant_e      last_grant_q, last_grant_d;
   logic        reg_inh_q, reg_inh_d;
   logic [4:0]  reg_addr_q, reg_addr_d;
   logic        reg_wr_q, reg_wr_d;
   logic [31:0] reg_wdata_q, reg_wdata_d;
   logic        a_done_q, a_done_d;
   logic        b_done_q, b_done_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;
   logic        busy_q, busy_d;
   logic        grant_a;
   logic        finish;

`ifdef CORETSE_REG_TIMEOUT_EN
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   logic [TO_W-1:0] to_ctr_q, to_ctr_d;
   logic [TO_W-1:0] timeout_cnt_q, timeout_cnt_d;
   logic            rsp_err_q, rsp_err_d;
`endif

   // Next-state logic: grant in IDLE, wait for ack (or timeout) in ACCESS, pulse done in RESP.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      reg_inh_d    = reg_inh_q;
      reg_addr_d   = reg_addr_q;
      reg_wr_d     = reg_wr_q;
      reg_wdata_d  = reg_wdata_q;
      a_done_d     = 1'b0;
      b_done_d     = 1'b0;
      rsp_rdata_d  = rsp_rdata_q;
      grant_a      = 1'b0;
      finish       = 1'b0;
`ifdef CORETSE_REG_TIMEOUT_EN
      to_ctr_d      = to_ctr_q;
      timeout_cnt_d = timeout_cnt_q;
      rsp_err_d     = rsp_err_q;
`endif
      case (state_q)
         IDLE: begin
            if (a_req || b_req) begin
               // On contention the port that was not served last wins.
               grant_a      = a_req && (!b_req || (last_grant_q == GRANT_B));
               last_grant_d = grant_a ? GRANT_A : GRANT_B;
               reg_wr_d     = grant_a ? a_wr    : b_wr;
               reg_addr_d   = grant_a ? a_addr  : b_addr;
               reg_wdata_d  = grant_a ? a_wdata : b_wdata;
               reg_inh_d    = 1'b0;
               state_d      = ACCESS;
`ifdef CORETSE_REG_TIMEOUT_EN
               to_ctr_d     = '0;
`endif
            end
         end
         ACCESS: begin
            if (reg_ack) begin
               rsp_rdata_d = reg_rdata;
               finish      = 1'b1;
`ifdef CORETSE_REG_TIMEOUT_EN
               rsp_err_d   = 1'b0;
`endif
            end
`ifdef CORETSE_REG_TIMEOUT_EN
            else if (to_ctr_q == TO_LAST) begin
               rsp_rdata_d = '0;
               rsp_err_d   = 1'b1;
               finish      = 1'b1;
               if (timeout_cnt_q != {TO_W{1'b1}}) begin
                  timeout_cnt_d = timeout_cnt_q + TO_W'(1);
               end
            end else begin
               to_ctr_d = to_ctr_q + TO_W'(1);
            end
`endif
            if (finish) begin
               state_d   = RESP;
               reg_inh_d = 1'b1;
               reg_wr_d  = 1'b0;
               a_done_d  = (last_grant_q == GRANT_A);
               b_done_d  = (last_grant_q == GRANT_B);
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q      <= IDLE;
         last_grant_q <= GRANT_B;
         reg_inh_q    <= 1'b1;
         reg_addr_q   <= '0;
         reg_wr_q     <= 1'b0;
         reg_wdata_q  <= '0;
         a_done_q     <= 1'b0;
         b_done_q     <= 1'b0;
         rsp_rdata_q  <= '0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         reg_inh_q    <= reg_inh_d;
         reg_addr_q   <= reg_addr_d;
         reg_wr_q     <= reg_wr_d;
         reg_wdata_q  <= reg_wdata_d;
         a_done_q     <= a_done_d;
         b_done_q     <= b_done_d;
         rsp_rdata_q  <= rsp_rdata_d;
         busy_q       <= busy_d;
      end
   end

`ifdef CORETSE_REG_TIMEOUT_EN
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         to_ctr_q      <= '0;
         timeout_cnt_q <= '0;
         rsp_err_q     <= 1'b0;
      end else begin
         to_ctr_q      <= to_ctr_d;
         timeout_cnt_q <= timeout_cnt_d;
         rsp_err_q     <= rsp_err_d;
      end
   end

   assign rsp_err     = rsp_err_q;
   assign timeout_cnt = timeout_cnt_q;
`else
   assign rsp_err     = 1'b0;
   assign timeout_cnt = '0;
`endif

   assign reg_inh   = reg_inh_q;
   assign reg_addr  = reg_addr_q;
   assign reg_wr    = reg_wr_q;
   assign reg_wdata = reg_wdata_q;
   assign a_done    = a_done_q;
   assign b_done    = b_done_q;
   assign rsp_rdata = rsp_rdata_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Testbench for reg_bus_arbiter: requesters and decoder are driven from tasks and checked against
// a transaction-level model (round-robin grant, ack latency, timeout rule).
module tb_reg_bus_arbiter;

   localparam int TO   = 4;
   localparam int TO_W = 8;

   logic            HCLK = 1'b0;
   logic            HRESETn;
   logic            a_req, a_wr, b_req, b_wr;
   logic [4:0]      a_addr, b_addr;
   logic [31:0]     a_wdata, b_wdata;
   logic            a_done, b_done;
   logic [31:0]     rsp_rdata;
   logic            rsp_err;
   logic            reg_inh;
   logic [4:0]      reg_addr;
   logic            reg_wr;
   logic [31:0]     reg_wdata;
   logic [31:0]     reg_rdata;
   logic            reg_ack;
   logic            busy;
   logic [TO_W-1:0] timeout_cnt;

   int errors = 0;
   int checks = 0;

   // Reference state: who was served last, and how many timeouts have been reported.
   bit              lastGrantA;
   logic [TO_W-1:0] expTo;

   reg_bus_arbiter #(.TIMEOUT_CYCLES(TO), .TO_W(TO_W)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn),
      .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_wdata(a_wdata), .a_done(a_done),
      .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_wdata(b_wdata), .b_done(b_done),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .reg_inh(reg_inh), .reg_addr(reg_addr), .reg_wr(reg_wr), .reg_wdata(reg_wdata),
      .reg_rdata(reg_rdata), .reg_ack(reg_ack),
      .busy(busy), .timeout_cnt(timeout_cnt)
   );

   always #5 HCLK = ~HCLK;

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic raise_a(input logic wr, input logic [4:0] addr, input logic [31:0] wdata);
      a_req = 1'b1; a_wr = wr; a_addr = addr; a_wdata = wdata;
   endtask

   task automatic raise_b(input logic wr, input logic [4:0] addr, input logic [31:0] wdata);
      b_req = 1'b1; b_wr = wr; b_addr = addr; b_wdata = wdata;
   endtask

   // One complete access from an IDLE negedge with requests driven, ending at the following IDLE negedge.
   task automatic access_one(input int ackDelay, input logic [31:0] rdata, input bit expectTimeout,
                             input string name);
      bit          grantA;
      bit          stableOk;
      logic [4:0]  eAddr;
      logic        eWr;
      logic [31:0] eWdata;
      logic [31:0] eData;
      int          cyc;
      int          eCycles;
      grantA = a_req && (!b_req || !lastGrantA);
      eAddr  = grantA ? a_addr  : b_addr;
      eWr    = grantA ? a_wr    : b_wr;
      eWdata = grantA ? a_wdata : b_wdata;
      @(posedge HCLK); @(negedge HCLK);
      checks++;
      if (reg_inh !== 1'b0 || busy !== 1'b1 || reg_addr !== eAddr || reg_wr !== eWr || reg_wdata !== eWdata) begin
         errors++;
         $display("[TB] FAIL %s_grant: inh=%b busy=%b addr=%h wr=%b wdata=%h, required inh=0 busy=1 addr=%h wr=%b wdata=%h",
                  name, reg_inh, busy, reg_addr, reg_wr, reg_wdata, eAddr, eWr, eWdata);
      end
      lastGrantA = grantA;
      stableOk   = 1'b1;
      cyc        = 1;
      while (cyc <= 300) begin
         reg_ack   = (cyc == ackDelay + 1);
         reg_rdata = reg_ack ? rdata : $urandom;
         @(posedge HCLK); @(negedge HCLK);
         reg_ack = 1'b0;
         if (reg_inh !== 1'b0) break;
         if (busy !== 1'b1 || reg_addr !== eAddr || reg_wr !== eWr || reg_wdata !== eWdata) stableOk = 1'b0;
         cyc++;
      end
      checks++;
      if (!stableOk) begin
         errors++;
         $display("[TB] FAIL %s_stable: bus changed during access, required addr=%h wr=%b wdata=%h",
                  name, eAddr, eWr, eWdata);
      end
      eCycles = expectTimeout ? TO : ackDelay + 1;
      checks++;
      if (cyc !== eCycles) begin
         errors++;
         $display("[TB] FAIL %s_latency: access cycles=%0d, required %0d", name, cyc, eCycles);
      end
      checks++;
      if (a_done !== grantA || b_done !== !grantA) begin
         errors++;
         $display("[TB] FAIL %s_done: a_done=%b b_done=%b, required a_done=%b b_done=%b",
                  name, a_done, b_done, grantA, !grantA);
      end
      eData = expectTimeout ? 32'h0 : rdata;
      checks++;
      if (rsp_rdata !== eData || rsp_err !== expectTimeout || reg_wr !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL %s_resp: rdata=%h err=%b wr=%b busy=%b, required rdata=%h err=%b wr=0 busy=1",
                  name, rsp_rdata, rsp_err, reg_wr, busy, eData, expectTimeout);
      end
      if (expectTimeout && expTo != {TO_W{1'b1}}) expTo = expTo + 1'b1;
      checks++;
      if (timeout_cnt !== expTo) begin
         errors++;
         $display("[TB] FAIL %s_tocnt: timeout_cnt=%0d, required %0d", name, timeout_cnt, expTo);
      end
      if (grantA) a_req = 1'b0; else b_req = 1'b0;
      @(posedge HCLK); @(negedge HCLK);
      checks++;
      if (a_done !== 1'b0 || b_done !== 1'b0 || busy !== 1'b0 || reg_inh !== 1'b1 || rsp_rdata !== eData) begin
         errors++;
         $display("[TB] FAIL %s_idle: a_done=%b b_done=%b busy=%b inh=%b rdata=%h, required 0 0 0 1 %h",
                  name, a_done, b_done, busy, reg_inh, rsp_rdata, eData);
      end
   endtask

   task automatic drop_all();
      a_req = 1'b0; b_req = 1'b0;
      @(posedge HCLK); @(negedge HCLK);
   endtask

   task automatic test_reset();
      HRESETn = 1'b0;
      a_req = 0; a_wr = 0; a_addr = 0; a_wdata = 0;
      b_req = 0; b_wr = 0; b_addr = 0; b_wdata = 0;
      reg_rdata = 0; reg_ack = 0;
      lastGrantA = 1'b0;
      expTo = '0;
      repeat (3) @(negedge HCLK);
      HRESETn = 1'b1;
      @(posedge HCLK); @(negedge HCLK);
      checks++;
      if (reg_inh !== 1'b1 || reg_addr !== 5'h0 || reg_wr !== 1'b0 || reg_wdata !== 32'h0 ||
          a_done !== 1'b0 || b_done !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0 ||
          busy !== 1'b0 || timeout_cnt !== '0) begin
         errors++;
         $display("[TB] FAIL reset: inh=%b addr=%h wr=%b wdata=%h done=%b%b rdata=%h err=%b busy=%b tocnt=%0d, required inh=1 and all others 0",
                  reg_inh, reg_addr, reg_wr, reg_wdata, a_done, b_done, rsp_rdata, rsp_err, busy, timeout_cnt);
      end
   endtask

   task automatic test_contention();
      raise_a(1'b0, 5'h01, 32'h1111_0001);
      raise_b(1'b1, 5'h02, 32'h2222_0002);
      access_one(0, 32'hA000_0001, 1'b0, "cont1");
      raise_a(1'b1, 5'h03, 32'h1111_0003);
      access_one(1, 32'hB000_0002, 1'b0, "cont2");
      raise_b(1'b0, 5'h04, 32'h2222_0004);
      access_one(0, 32'hA000_0003, 1'b0, "cont3");
      raise_a(1'b0, 5'h05, 32'h1111_0005);
      access_one(2, 32'hB000_0004, 1'b0, "cont4");
      drop_all();
   endtask

   task automatic test_single_read();
      raise_a(1'b0, 5'h04, 32'h0);
      access_one(2, 32'hCAFE_0123, 1'b0, "read");
      drop_all();
   endtask

   task automatic test_write();
      raise_b(1'b1, 5'h1C, 32'h0000_00A5);
      access_one(0, $urandom, 1'b0, "write");
      drop_all();
   endtask

`ifdef CORETSE_REG_TIMEOUT_EN
   task automatic test_timeout();
      raise_a(1'b0, 5'h0F, 32'h0);
      access_one(1000, 32'hDEAD_BEEF, 1'b1, "timeout");
      drop_all();
   endtask

   task automatic test_boundary();
      raise_a(1'b0, 5'h10, 32'h0);
      access_one(TO - 1, 32'h1234_5678, 1'b0, "boundary");
      drop_all();
   endtask
`endif

   task automatic test_random();
      for (int i = 0; i < 24; i++) begin
         if (!a_req && ($urandom_range(0, 1) == 1)) raise_a(1'($urandom), 5'($urandom), $urandom);
         if (!b_req && ($urandom_range(0, 1) == 1)) raise_b(1'($urandom), 5'($urandom), $urandom);
         if (!a_req && !b_req) raise_b(1'($urandom), 5'($urandom), $urandom);
         access_one(int'($urandom_range(0, TO - 1)), $urandom, 1'b0, "rand");
      end
      drop_all();
   endtask

   task automatic test_reset_mid_op();
      bit sawDone;
      raise_a(1'b1, 5'h07, 32'h7777_7777);
      @(posedge HCLK); @(negedge HCLK);
      @(posedge HCLK); @(negedge HCLK);
      HRESETn = 1'b0;
      #1;
      checks++;
      if (reg_inh !== 1'b1 || reg_addr !== 5'h0 || reg_wr !== 1'b0 || reg_wdata !== 32'h0 ||
          a_done !== 1'b0 || b_done !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0 ||
          busy !== 1'b0 || timeout_cnt !== '0) begin
         errors++;
         $display("[TB] FAIL midreset: inh=%b addr=%h wr=%b wdata=%h done=%b%b rdata=%h err=%b busy=%b tocnt=%0d, required inh=1 and all others 0",
                  reg_inh, reg_addr, reg_wr, reg_wdata, a_done, b_done, rsp_rdata, rsp_err, busy, timeout_cnt);
      end
      a_req = 1'b0;
      lastGrantA = 1'b0;
      expTo = '0;
      sawDone = 1'b0;
      repeat (2) begin
         @(negedge HCLK);
         if (a_done || b_done) sawDone = 1'b1;
      end
      HRESETn = 1'b1;
      repeat (2) begin
         @(negedge HCLK);
         if (a_done || b_done) sawDone = 1'b1;
      end
      checks++;
      if (sawDone) begin
         errors++;
         $display("[TB] FAIL midreset_nodone: done pulse=1, required 0");
      end
      raise_a(1'b0, 5'h08, 32'h0);
      raise_b(1'b0, 5'h09, 32'h0);
      access_one(0, 32'h5A5A_A5A5, 1'b0, "postreset");
      drop_all();
   endtask

   initial begin
      test_reset();
      test_contention();
      test_single_read();
      test_write();
`ifdef CORETSE_REG_TIMEOUT_EN
      test_timeout();
      test_boundary();
`endif
      test_random();
      test_reset_mid_op();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
